multicycle_main_fsm: RTL and testbench

- Main control state machine for the multi-cycle Yu Core. It sequences the shared ALU, the shared instruction/data memory port and the register file across several cycles per instruction.
- It drives the ALUOpcode field consumed by the existing ALUDecoder, using the same encoding: 00 add, 01 subtract, 10 decode from funct3/funct7/opcode5.
- It sits in the control unit beside ALUDecoder and the immediate-select decoder.

---
 rtl/multicycle_main_fsm.sv | 174 +++++++++++++++++
 tb/tb_multicycle_main_fsm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_main_fsm.sv
// Multi-cycle core main control FSM; lw 5, sw/R/I/jal 4, beq 3 cycles with zero-wait memory.
// Memory backpressure: FETCH/MEMREAD/MEMWRITE hold their request until MemReady is seen.
module multicycle_main_fsm #(
   parameter bit MEM_WAIT_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] Opcode,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOpcode,
   output logic       RegWrite,
   output logic       InstrDone,
   output logic       IllegalInstr,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECR    = 4'd6,
      EXECI    = 4'd7,
      ALUWB    = 4'd8,
      BEQ      = 4'd9,
      JAL      = 4'd10,
      TRAP     = 4'd11
   } state_t;

   state_t state, state_nxt;
   logic   mem_rdy;
   logic   pc_update;
   logic   branch;

   assign mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         FETCH:    if (mem_rdy) state_nxt = DECODE;
         DECODE: begin
            unique case (Opcode)
               7'b0000011, 7'b0100011: state_nxt = MEMADR;
               7'b0110011:             state_nxt = EXECR;
               7'b0010011:             state_nxt = EXECI;
               7'b1100011:             state_nxt = BEQ;
               7'b1101111:             state_nxt = JAL;
               default:                state_nxt = TRAP;
            endcase
         end
         MEMADR:   state_nxt = Opcode[5] ? MEMWRITE : MEMREAD;
         MEMREAD:  if (mem_rdy) state_nxt = MEMWB;
         MEMWB:    state_nxt = FETCH;
         MEMWRITE: if (mem_rdy) state_nxt = FETCH;
         EXECR:    state_nxt = ALUWB;
         EXECI:    state_nxt = ALUWB;
         ALUWB:    state_nxt = FETCH;
         BEQ:      state_nxt = FETCH;
         JAL:      state_nxt = ALUWB;
         TRAP:     state_nxt = TRAP;
         default:  state_nxt = TRAP;
      endcase
   end

   always_comb begin
      pc_update    = 1'b0;
      branch       = 1'b0;
      AdrSrc       = 1'b0;
      MemRead      = 1'b0;
      MemWrite     = 1'b0;
      IRWrite      = 1'b0;
      ResultSrc    = 2'b00;
      ALUSrcA      = 2'b00;
      ALUSrcB      = 2'b00;
      ALUOpcode    = 2'b00;
      RegWrite     = 1'b0;
      InstrDone    = 1'b0;
      IllegalInstr = 1'b0;
      unique case (state)
         FETCH: begin
            MemRead   = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            IRWrite   = mem_rdy;
            pc_update = mem_rdy;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
         end
         MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
         end
         MEMREAD: begin
            AdrSrc  = 1'b1;
            MemRead = 1'b1;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         MEMWRITE: begin
            AdrSrc    = 1'b1;
            MemWrite  = 1'b1;
            InstrDone = mem_rdy;
         end
         EXECR: begin
            ALUSrcA   = 2'b10;
            ALUOpcode = 2'b10;
         end
         EXECI: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            ALUOpcode = 2'b10;
         end
         ALUWB: begin
            RegWrite  = 1'b1;
            InstrDone = 1'b1;
         end
         BEQ: begin
            ALUSrcA   = 2'b10;
            ALUOpcode = 2'b01;
            branch    = 1'b1;
            InstrDone = 1'b1;
         end
         JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_update = 1'b1;
         end
         TRAP:    IllegalInstr = 1'b1;
         default: IllegalInstr = 1'b1;
      endcase

      PCWrite = pc_update | (branch & Zero);
      State   = state;

      // Reset holds the state at FETCH, which would otherwise raise MemRead.
      if (!rst_n) begin
         PCWrite      = 1'b0;
         AdrSrc       = 1'b0;
         MemRead      = 1'b0;
         MemWrite     = 1'b0;
         IRWrite      = 1'b0;
         ResultSrc    = 2'b00;
         ALUSrcA      = 2'b00;
         ALUSrcB      = 2'b00;
         ALUOpcode    = 2'b00;
         RegWrite     = 1'b0;
         InstrDone    = 1'b0;
         IllegalInstr = 1'b0;
         State        = 4'd0;
      end
   end

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed vector bench for multicycle_main_fsm: per-cycle inputs and hand-computed outputs.
module tb_multicycle_main_fsm;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] Opcode = 7'b0;
   logic       Zero = 1'b0;
   logic       MemReady = 1'b0;
   logic       PCWrite, AdrSrc, MemRead, MemWrite, IRWrite;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOpcode;
   logic       RegWrite, InstrDone, IllegalInstr;
   logic [3:0] State;

   multicycle_main_fsm #(.MEM_WAIT_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
      .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemRead(MemRead), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOpcode(ALUOpcode), .RegWrite(RegWrite), .InstrDone(InstrDone),
      .IllegalInstr(IllegalInstr), .State(State)
   );

   always #5 clk = ~clk;

   localparam logic [6:0] OP_LW = 7'b0000011, OP_SW = 7'b0100011, OP_R = 7'b0110011,
                          OP_I = 7'b0010011, OP_BEQ = 7'b1100011, OP_JAL = 7'b1101111,
                          OP_BAD = 7'b1111111;

   // Output bundle: {PCWrite,AdrSrc,MemRead,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,
   //                 ALUOpcode,RegWrite,InstrDone,IllegalInstr,State}
   function automatic logic [19:0] mk(input logic pcw, input logic adr, input logic mr,
                                      input logic mw, input logic irw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [1:0] op, input logic rw, input logic dn,
                                      input logic ill, input logic [3:0] st);
      return {pcw, adr, mr, mw, irw, rs, sa, sb, op, rw, dn, ill, st};
   endfunction

   typedef struct {
      logic        rst;
      logic [6:0]  opc;
      logic        zero;
      logic        rdy;
      logic [19:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];
   int   n_vec = 0;
   int   n_bad = 0;

   logic [19:0] E_RESET, E_FETCH_RDY, E_FETCH_WAIT, E_DECODE, E_MEMADR, E_MEMREAD, E_MEMWB,
                E_MEMWR_RDY, E_MEMWR_WAIT, E_EXECR, E_EXECI, E_ALUWB, E_BEQ_T, E_BEQ_N,
                E_JAL, E_TRAP;

   function automatic logic [19:0] actual();
      return {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
              ALUOpcode, RegWrite, InstrDone, IllegalInstr, State};
   endfunction

   task automatic add(input logic rst, input logic [6:0] opc, input logic z, input logic rdy,
                      input logic [19:0] exp, input string name);
      vec_t v;
      v.rst = rst; v.opc = opc; v.zero = z; v.rdy = rdy; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [19:0] exp);
      logic [19:0] act;
      act = actual();
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %05h (state %0d) expected %05h (state %0d)",
                  name, act, act[3:0], exp, exp[3:0]);
      end
      if (MemRead && MemWrite) begin
         n_bad++;
         $display("FAIL %s: MemRead and MemWrite both high, got 1 expected 0", name);
      end
   endtask

   task automatic drive(input logic rst, input logic [6:0] opc, input logic z, input logic rdy);
      rst_n = rst; Opcode = opc; Zero = z; MemReady = rdy;
   endtask

   initial begin
      E_RESET      = '0;
      E_FETCH_RDY  = mk(1,0,1,0,1, 2'b10,2'b00,2'b10,2'b00, 0,0,0, 4'd0);
      E_FETCH_WAIT = mk(0,0,1,0,0, 2'b10,2'b00,2'b10,2'b00, 0,0,0, 4'd0);
      E_DECODE     = mk(0,0,0,0,0, 2'b00,2'b01,2'b01,2'b00, 0,0,0, 4'd1);
      E_MEMADR     = mk(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b00, 0,0,0, 4'd2);
      E_MEMREAD    = mk(0,1,1,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0, 4'd3);
      E_MEMWB      = mk(0,0,0,0,0, 2'b01,2'b00,2'b00,2'b00, 1,1,0, 4'd4);
      E_MEMWR_RDY  = mk(0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,1,0, 4'd5);
      E_MEMWR_WAIT = mk(0,1,0,1,0, 2'b00,2'b00,2'b00,2'b00, 0,0,0, 4'd5);
      E_EXECR      = mk(0,0,0,0,0, 2'b00,2'b10,2'b00,2'b10, 0,0,0, 4'd6);
      E_EXECI      = mk(0,0,0,0,0, 2'b00,2'b10,2'b01,2'b10, 0,0,0, 4'd7);
      E_ALUWB      = mk(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 1,1,0, 4'd8);
      E_BEQ_T      = mk(1,0,0,0,0, 2'b00,2'b10,2'b00,2'b01, 0,1,0, 4'd9);
      E_BEQ_N      = mk(0,0,0,0,0, 2'b00,2'b10,2'b00,2'b01, 0,1,0, 4'd9);
      E_JAL        = mk(1,0,0,0,0, 2'b00,2'b01,2'b10,2'b00, 0,0,0, 4'd10);
      E_TRAP       = mk(0,0,0,0,0, 2'b00,2'b00,2'b00,2'b00, 0,0,1, 4'd11);

      // reset holds everything low even with MemReady high
      add(0, OP_R,   1, 1, E_RESET,      "reset0");
      add(0, OP_LW,  0, 1, E_RESET,      "reset1");
      // R-type: 0,1,6,8 (MemReady low outside memory states is ignored)
      add(1, OP_R,   0, 1, E_FETCH_RDY,  "r_fetch");
      add(1, OP_R,   0, 0, E_DECODE,     "r_decode");
      add(1, OP_R,   0, 0, E_EXECR,      "r_exec");
      add(1, OP_R,   0, 0, E_ALUWB,      "r_aluwb");
      // I-type
      add(1, OP_I,   0, 1, E_FETCH_RDY,  "i_fetch");
      add(1, OP_I,   0, 1, E_DECODE,     "i_decode");
      add(1, OP_I,   0, 1, E_EXECI,      "i_exec");
      add(1, OP_I,   0, 1, E_ALUWB,      "i_aluwb");
      // lw with 2 fetch waits and 3 memread waits: 10 cycles
      add(1, OP_LW,  0, 0, E_FETCH_WAIT, "lw_fetch_w0");
      add(1, OP_LW,  0, 0, E_FETCH_WAIT, "lw_fetch_w1");
      add(1, OP_LW,  0, 1, E_FETCH_RDY,  "lw_fetch");
      add(1, OP_LW,  0, 0, E_DECODE,     "lw_decode");
      add(1, OP_LW,  0, 1, E_MEMADR,     "lw_memadr");
      add(1, OP_LW,  0, 0, E_MEMREAD,    "lw_mrd_w0");
      add(1, OP_LW,  0, 0, E_MEMREAD,    "lw_mrd_w1");
      add(1, OP_LW,  0, 0, E_MEMREAD,    "lw_mrd_w2");
      add(1, OP_LW,  0, 1, E_MEMREAD,    "lw_mrd");
      add(1, OP_LW,  0, 0, E_MEMWB,      "lw_memwb");
      // sw zero-wait: 0,1,2,5
      add(1, OP_SW,  0, 1, E_FETCH_RDY,  "sw_fetch");
      add(1, OP_SW,  0, 1, E_DECODE,     "sw_decode");
      add(1, OP_SW,  0, 1, E_MEMADR,     "sw_memadr");
      add(1, OP_SW,  0, 1, E_MEMWR_RDY,  "sw_memwr");
      // sw with one write wait: MemWrite held, InstrDone only on ready
      add(1, OP_SW,  0, 1, E_FETCH_RDY,  "sw2_fetch");
      add(1, OP_SW,  0, 1, E_DECODE,     "sw2_decode");
      add(1, OP_SW,  0, 1, E_MEMADR,     "sw2_memadr");
      add(1, OP_SW,  0, 0, E_MEMWR_WAIT, "sw2_memwr_w");
      add(1, OP_SW,  0, 1, E_MEMWR_RDY,  "sw2_memwr");
      // beq taken then not taken
      add(1, OP_BEQ, 0, 1, E_FETCH_RDY,  "beq1_fetch");
      add(1, OP_BEQ, 0, 1, E_DECODE,     "beq1_decode");
      add(1, OP_BEQ, 1, 1, E_BEQ_T,      "beq1_taken");
      add(1, OP_BEQ, 1, 1, E_FETCH_RDY,  "beq2_fetch");
      add(1, OP_BEQ, 1, 1, E_DECODE,     "beq2_decode");
      add(1, OP_BEQ, 0, 1, E_BEQ_N,      "beq2_nottaken");
      // jal: 0,1,10,8
      add(1, OP_JAL, 0, 1, E_FETCH_RDY,  "jal_fetch");
      add(1, OP_JAL, 0, 1, E_DECODE,     "jal_decode");
      add(1, OP_JAL, 0, 1, E_JAL,        "jal_jal");
      add(1, OP_JAL, 0, 1, E_ALUWB,      "jal_aluwb");
      // unsupported opcode traps and stays trapped
      add(1, OP_BAD, 0, 1, E_FETCH_RDY,  "bad_fetch");
      add(1, OP_BAD, 0, 1, E_DECODE,     "bad_decode");
      for (int k = 0; k < 20; k++)
         add(1, (k % 2 == 0) ? OP_R : OP_LW, k[0], k[1], E_TRAP, $sformatf("trap_%0d", k));

      foreach (vecs[i]) begin
         @(posedge clk);
         #1 drive(vecs[i].rst, vecs[i].opc, vecs[i].zero, vecs[i].rdy);
         @(negedge clk);
         check(vecs[i].name, vecs[i].exp);
      end

      // Asynchronous reset during a MEMREAD wait.
      @(posedge clk); #1 drive(0, OP_LW, 0, 1);
      @(negedge clk); check("ar_reset", E_RESET);
      @(posedge clk); #1 drive(1, OP_LW, 0, 1);
      @(negedge clk); check("ar_fetch", E_FETCH_RDY);
      @(posedge clk); #1 drive(1, OP_LW, 0, 1);
      @(negedge clk); check("ar_decode", E_DECODE);
      @(posedge clk); #1 drive(1, OP_LW, 0, 1);
      @(negedge clk); check("ar_memadr", E_MEMADR);
      @(posedge clk); #1 drive(1, OP_LW, 0, 0);
      @(negedge clk); check("ar_memread_w", E_MEMREAD);
      #2 rst_n = 1'b0;
      #1 check("ar_async_clear", E_RESET);
      @(posedge clk); #1 drive(0, OP_LW, 0, 1);
      @(negedge clk); check("ar_held", E_RESET);
      @(posedge clk); #1 drive(1, OP_LW, 0, 1);
      @(negedge clk); check("ar_refetch", E_FETCH_RDY);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
